// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

  // Each output FIFO holds two messages: enough for full throughput with a registered ready.
  localparam int FIFO_DEPTH = 2;

  // Occupancy count, range 0..FIFO_DEPTH.
  typedef logic [1:0] fifo_count_t;

  localparam fifo_count_t COUNT_EMPTY = 2'd0;
  localparam fifo_count_t COUNT_FULL  = 2'd2;

  // in_sel encoding.
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/stream_fifo_2entry.sv
// Two-entry val/rdy FIFO. enq_rdy depends only on registered occupancy, so there is
// no combinational path from deq_rdy back to enq_rdy; a full FIFO refuses new data
// even in a cycle where it is being drained.
module stream_fifo_2entry
  import stream_demux_pkg::*;
#(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [nbits-1:0] enq_msg,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [nbits-1:0] deq_msg
);

  logic [nbits-1:0] r_mem [FIFO_DEPTH];
  logic             r_enq_ptr;
  logic             r_deq_ptr;
  fifo_count_t      r_count;

  logic w_enq_xfer;
  logic w_deq_xfer;

  assign enq_rdy    = (r_count != COUNT_FULL);
  assign deq_val    = (r_count != COUNT_EMPTY);
  assign deq_msg    = r_mem[r_deq_ptr];
  assign w_enq_xfer = enq_val && enq_rdy;
  assign w_deq_xfer = deq_val && deq_rdy;

  // Storage write; payload entries carry no reset since valid is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_enq_xfer) begin
      r_mem[r_enq_ptr] <= enq_msg;
    end
  end

  // Pointer and occupancy update; simultaneous enq and deq leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enq_ptr <= 1'b0;
      r_deq_ptr <= 1'b0;
      r_count   <= COUNT_EMPTY;
    end else begin
      if (w_enq_xfer) begin
        r_enq_ptr <= ~r_enq_ptr;
      end
      if (w_deq_xfer) begin
        r_deq_ptr <= ~r_deq_ptr;
      end
      case ({w_enq_xfer, w_deq_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stream_param_1to2_demux.sv
// 1-to-2 stream demultiplexer: each accepted input message is steered by in_sel into
// a private 2-entry FIFO per output, so a stalled output never blocks the other one.
module stream_param_1to2_demux
  import stream_demux_pkg::*;
#(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_msg,
  input  logic             in_sel,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [nbits-1:0] out0_msg,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [nbits-1:0] out1_msg
);

  logic [1:0]       w_enq_val;
  logic [1:0]       w_enq_rdy;
  logic [1:0]       w_deq_val;
  logic [1:0]       w_deq_rdy;
  logic [nbits-1:0] w_deq_msg [2];
  logic             w_sel_rdy;

  // Only the FIFO named by in_sel sees the valid; the other stays untouched.
  assign w_enq_val[0] = in_val && (in_sel == SEL_OUT0);
  assign w_enq_val[1] = in_val && (in_sel == SEL_OUT1);
  assign w_deq_rdy    = {out1_rdy, out0_rdy};

  // Ready follows the selected FIFO's registered fullness; held low while reset is asserted.
  always_comb begin
    w_sel_rdy = w_enq_rdy[0];
    if (in_sel == SEL_OUT1) begin
      w_sel_rdy = w_enq_rdy[1];
    end
    in_rdy = reset_n && w_sel_rdy;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out_fifo
      stream_fifo_2entry #(
        .nbits (nbits)
      ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_val (w_enq_val[gi]),
        .enq_rdy (w_enq_rdy[gi]),
        .enq_msg (in_msg),
        .deq_val (w_deq_val[gi]),
        .deq_rdy (w_deq_rdy[gi]),
        .deq_msg (w_deq_msg[gi])
      );
    end
  endgenerate

  assign out0_val = w_deq_val[0];
  assign out0_msg = w_deq_msg[0];
  assign out1_val = w_deq_val[1];
  assign out1_msg = w_deq_msg[1];

endmodule

// File: tb/tb_stream_param_1to2_demux.sv
// Directed self-checking bench for stream_param_1to2_demux (nbits = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_stream_param_1to2_demux;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_val = 1'b0;
  logic       in_rdy;
  logic [7:0] in_msg = 8'h00;
  logic       in_sel = 1'b0;
  logic       out0_val;
  logic       out0_rdy = 1'b0;
  logic [7:0] out0_msg;
  logic       out1_val;
  logic       out1_rdy = 1'b0;
  logic [7:0] out1_msg;

  int n_checks = 0;
  int n_errors = 0;

  stream_param_1to2_demux #(
    .nbits (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .in_sel   (in_sel),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic val, input logic sel, input logic [7:0] msg);
    in_val = val;
    in_sel = sel;
    in_msg = msg;
    #1;
  endtask

  // One line per transfer on any interface.
  always @(posedge clk) begin
    if (reset_n) begin
      if (in_val && in_rdy) $display("%0t IN   sel=%0d msg=%02h", $time, in_sel, in_msg);
      if (out0_val && out0_rdy) $display("%0t OUT0 msg=%02h", $time, out0_msg);
      if (out1_val && out1_rdy) $display("%0t OUT1 msg=%02h", $time, out1_msg);
    end
  end

  // Upstream must hold a stalled message stable until it is accepted.
  logic       p_stall = 1'b0;
  logic [7:0] p_msg = 8'h00;
  logic       p_sel = 1'b0;
  always @(posedge clk) begin
    if (reset_n && p_stall) begin
      assert (in_val && in_msg == p_msg && in_sel == p_sel)
        else $error("upstream changed a stalled input message");
    end
    p_stall = reset_n && in_val && !in_rdy;
    p_msg   = in_msg;
    p_sel   = in_sel;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] msgs [32];
  int         n_rx;

  initial begin
    // ---------------- reset then idle ----------------
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", 8'(in_rdy), 8'h0);
    check("rst_out0_val", 8'(out0_val), 8'h0);
    check("rst_out1_val", 8'(out1_val), 8'h0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_rdy", 8'(in_rdy), 8'h1);
    check("post_rst_out0_val", 8'(out0_val), 8'h0);
    check("post_rst_out1_val", 8'(out1_val), 8'h0);
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_out0_val", 8'(out0_val), 8'h0);
      check("idle_out1_val", 8'(out1_val), 8'h0);
    end

    // ---------------- steering ----------------
    drive(1'b1, 1'b0, 8'h11);
    check("steer_rdy_11", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("steer_out0_val_11", 8'(out0_val), 8'h1);
    check("steer_out0_msg_11", out0_msg, 8'h11);
    check("steer_out1_val_a", 8'(out1_val), 8'h0);
    drive(1'b1, 1'b1, 8'h22);
    check("steer_rdy_22", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("steer_out0_val_a", 8'(out0_val), 8'h0);
    check("steer_out1_val_22", 8'(out1_val), 8'h1);
    check("steer_out1_msg_22", out1_msg, 8'h22);
    drive(1'b1, 1'b0, 8'h33);
    check("steer_rdy_33", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("steer_out0_val_33", 8'(out0_val), 8'h1);
    check("steer_out0_msg_33", out0_msg, 8'h33);
    check("steer_out1_val_b", 8'(out1_val), 8'h0);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("steer_drain_out0", 8'(out0_val), 8'h0);
    check("steer_drain_out1", 8'(out1_val), 8'h0);

    // ---------------- full and independence ----------------
    out0_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'hA0);
    check("full_rdy_a0", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("full_out0_val_a0", 8'(out0_val), 8'h1);
    check("full_out0_msg_a0", out0_msg, 8'hA0);
    drive(1'b1, 1'b0, 8'hA1);
    check("full_rdy_a1", 8'(in_rdy), 8'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'hA2);
    check("full_rdy_sel0", 8'(in_rdy), 8'h0);
    drive(1'b1, 1'b1, 8'hB0);
    check("indep_rdy_b0", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("indep_out1_val_b0", 8'(out1_val), 8'h1);
    check("indep_out1_msg_b0", out1_msg, 8'hB0);
    check("indep_out0_msg_a0", out0_msg, 8'hA0);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("indep_out1_drained", 8'(out1_val), 8'h0);

    // ---------------- full with same-cycle dequeue ----------------
    out0_rdy = 1'b1;
    drive(1'b1, 1'b0, 8'hC0);
    check("samecyc_rdy", 8'(in_rdy), 8'h0);
    check("samecyc_head_a0", out0_msg, 8'hA0);
    @(negedge clk);
    check("samecyc_out0_val_a1", 8'(out0_val), 8'h1);
    check("samecyc_head_a1", out0_msg, 8'hA1);
    check("samecyc_rdy_next", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("samecyc_out0_val_c0", 8'(out0_val), 8'h1);
    check("samecyc_head_c0", out0_msg, 8'hC0);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("samecyc_drained", 8'(out0_val), 8'h0);
    check("samecyc_rdy_sel0", 8'(in_rdy), 8'h1);

    // ---------------- sustained throughput on out1 ----------------
    for (int i = 0; i < 32; i++) msgs[i] = 8'($urandom_range(0, 255));
    out1_rdy = 1'b1;
    n_rx = 0;
    for (int c = 0; c <= 32; c++) begin
      if (c >= 1) begin
        check("thru_out1_val", 8'(out1_val), 8'h1);
        check("thru_out1_msg", out1_msg, msgs[c-1]);
        if (out1_val && out1_msg === msgs[c-1]) n_rx++;
      end
      if (c < 32) begin
        drive(1'b1, 1'b1, msgs[c]);
        check("thru_in_rdy", 8'(in_rdy), 8'h1);
      end else begin
        drive(1'b0, 1'b0, 8'h00);
      end
      @(negedge clk);
    end
    check("thru_out1_empty", 8'(out1_val), 8'h0);
    check("thru_rx_count", 8'(n_rx), 8'd32);

    // ---------------- reset mid-operation ----------------
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'h01);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h02);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h03);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h04);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    check("midrst_full0", 8'(in_rdy), 8'h0);
    check("midrst_out0_msg", out0_msg, 8'h01);
    check("midrst_out1_msg", out1_msg, 8'h03);
    drive(1'b0, 1'b1, 8'h00);
    check("midrst_full1", 8'(in_rdy), 8'h0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_async_out0_val", 8'(out0_val), 8'h0);
    check("midrst_async_out1_val", 8'(out1_val), 8'h0);
    check("midrst_async_in_rdy", 8'(in_rdy), 8'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    check("midrst_rel_in_rdy", 8'(in_rdy), 8'h1);
    check("midrst_rel_out0_val", 8'(out0_val), 8'h0);
    check("midrst_rel_out1_val", 8'(out1_val), 8'h0);
    out0_rdy = 1'b1;
    drive(1'b1, 1'b0, 8'h5A);
    check("midrst_rdy_5a", 8'(in_rdy), 8'h1);
    @(negedge clk);
    check("midrst_out0_val_5a", 8'(out0_val), 8'h1);
    check("midrst_out0_msg_5a", out0_msg, 8'h5A);
    check("midrst_out1_val", 8'(out1_val), 8'h0);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("midrst_out0_drained", 8'(out0_val), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
